// File: rtl/riscv_defines.sv
// Shared fetch-path definitions: default queue depth and the buffered entry format.
package riscv_defines;

  localparam int unsigned FETCH_QUEUE_DEPTH = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Circular buffer of fetched {address, instruction} pairs with single-cycle flush.
module riscv_fetch_fifo
  import riscv_defines::*;
#(
  parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop & ~empty;
  // A pop frees the head slot in the same cycle, so a push into a full FIFO is safe then.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/riscv_fetch_queue.sv
// Instruction prefetch queue: one outstanding memory transaction, buffered words, branch flush.
//   state       | meaning
//   IDLE        | no transaction outstanding
//   WAIT_GNT    | instr_req_o high, address held until granted
//   WAIT_RVALID | granted, waiting for the response word
module riscv_fetch_queue
  import riscv_defines::*;
#(
  parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID
  } state_t;

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);

  state_t        state;
  state_t        state_nxt;
  logic          discard;
  logic          discard_nxt;
  logic [31:0]   ptr;
  logic [31:0]   req_addr;
  logic [31:0]   target;
  logic [31:0]   fetch_addr;
  logic          issue;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  fetch_entry_t  wentry;
  fetch_entry_t  head;

  assign target     = word_align(addr_i);
  assign fetch_addr = branch_i ? target : ptr;
  assign pop        = ~empty & ready_i & ~branch_i;
  assign wentry     = '{addr: req_addr, data: instr_rdata_i};

  always_comb begin
    state_nxt   = state;
    discard_nxt = discard;
    issue       = 1'b0;
    push        = 1'b0;
    case (state)
      IDLE: begin
        discard_nxt = 1'b0;
        if (req_i && !full) begin
          state_nxt = WAIT_GNT;
          issue     = 1'b1;
        end
      end
      WAIT_GNT: begin
        if (branch_i)    discard_nxt = 1'b1;
        if (instr_gnt_i) state_nxt   = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (instr_rvalid_i) begin
          push        = ~discard & ~branch_i;
          discard_nxt = 1'b0;
          // Space check counts the transaction just completing as still outstanding.
          if (req_i && (count < DEPTH_M1)) begin
            state_nxt = WAIT_GNT;
            issue     = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (branch_i) begin
          discard_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      discard  <= 1'b0;
      ptr      <= '0;
      req_addr <= '0;
    end else begin
      state   <= state_nxt;
      discard <= discard_nxt;
      // After a redirect the pointer already holds the target; the stale grant must not bump it.
      if (branch_i)
        ptr <= target;
      else if (state == WAIT_GNT && instr_gnt_i && !discard)
        ptr <= ptr + 32'd4;
      if (issue) req_addr <= fetch_addr;
    end
  end

  riscv_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (branch_i),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign valid_o      = ~empty;
  assign addr_o       = head.addr;
  assign rdata_o      = head.data;
  assign instr_req_o  = (state == WAIT_GNT);
  assign instr_addr_o = req_addr;
  assign busy_o       = (state != IDLE) | ~empty;

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Directed bench for riscv_fetch_queue: memory responder model plus scoreboard monitor.
module tb_riscv_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        ready_i = 1'b0;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic [31:0] addr_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] exp_e;

  int          gnt_lat = 0;
  int          rv_lat  = 0;
  bit          gcount  = 0;
  int          gcnt    = 0;
  bit          pend    = 0;
  int          pwait   = 0;
  logic [31:0] paddr   = '0;

  riscv_fetch_queue #(.DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .addr_i         (addr_i),
    .ready_i        (ready_i),
    .valid_o        (valid_o),
    .rdata_o        (rdata_o),
    .addr_o         (addr_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] a);
    exp_q.push_back({a, data_of(a)});
  endtask

  // One clock; responder drives gnt/rvalid for the coming edge from what the DUT shows now.
  task automatic step();
    @(posedge clk);
    #2;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    if (pend) begin
      if (pwait == 0) begin
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = data_of(paddr);
        pend = 0;
      end else pwait--;
    end
    if (instr_req_o) begin
      if (!gcount) begin
        gcount = 1;
        gcnt   = gnt_lat;
      end
      if (gcnt == 0) begin
        instr_gnt_i = 1'b1;
        gcount = 0;
        pend   = 1;
        pwait  = rv_lat;
        paddr  = instr_addr_o;
      end else gcnt--;
    end
  endtask

  task automatic wait_req(input logic [31:0] a, input string name);
    int n = 0;
    while (!(instr_req_o && instr_addr_o == a) && n < 50) begin
      step();
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL %s: request for %h not seen within 50 cycles (last addr %h)", name, a, instr_addr_o);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o && n < 100) begin
      step();
      n++;
    end
    check({name, "_idle"}, {31'd0, busy_o}, 32'd0);
    check({name, "_drained"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n && valid_o && ready_i && !branch_i) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_word: got addr %h data %h, expected none", addr_o, rdata_o);
      end else begin
        exp_e = exp_q.pop_front();
        if ({addr_o, rdata_o} !== exp_e) begin
          bad++;
          $display("FAIL pop_word: got %h/%h expected %h/%h", addr_o, rdata_o, exp_e[63:32], exp_e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_req", {31'd0, instr_req_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_addr", addr_o, 32'd0);
    check("rst_iaddr", instr_addr_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Redirect to 0x80, zero-latency memory: two words with exact timing.
    expect_word(32'h80);
    expect_word(32'h84);
    ready_i = 1; req_i = 1; branch_i = 1; addr_i = 32'h80;
    step();
    branch_i = 0;
    check("t1_req_c1", {31'd0, instr_req_o}, 32'd1);
    check("t1_iaddr_c1", instr_addr_o, 32'h80);
    step();
    check("t1_req_c2", {31'd0, instr_req_o}, 32'd0);
    step();
    check("t1_valid_c3", {31'd0, valid_o}, 32'd1);
    check("t1_addr_c3", addr_o, 32'h80);
    check("t1_req_c3", {31'd0, instr_req_o}, 32'd1);
    check("t1_iaddr_c3", instr_addr_o, 32'h84);
    req_i = 0;
    wait_idle("t1");

    // Misaligned target, pointer wraps past the top of memory.
    expect_word(32'hFFFF_FFFC);
    expect_word(32'h0000_0000);
    req_i = 1; branch_i = 1; addr_i = 32'hFFFF_FFFF;
    step();
    branch_i = 0;
    check("wrap_iaddr", instr_addr_o, 32'hFFFF_FFFC);
    wait_req(32'h0, "wrap_req");
    req_i = 0;
    wait_idle("wrap");

    // Consumer stalled: exactly two words buffered, no further requests.
    expect_word(32'h100);
    expect_word(32'h104);
    ready_i = 0; req_i = 1; branch_i = 1; addr_i = 32'h100;
    step();
    branch_i = 0;
    for (int i = 0; i < 12; i++) step();
    check("full_valid", {31'd0, valid_o}, 32'd1);
    check("full_head", addr_o, 32'h100);
    check("full_busy", {31'd0, busy_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("full_no_req", {31'd0, instr_req_o}, 32'd0);
      step();
    end
    req_i = 0; ready_i = 1;
    wait_idle("full");

    // Grant withheld for three cycles: request and address stay put.
    expect_word(32'h40);
    gnt_lat = 3;
    req_i = 1; branch_i = 1; addr_i = 32'h40;
    step();
    branch_i = 0; req_i = 0;
    for (int i = 0; i < 4; i++) begin
      check("hold_req", {31'd0, instr_req_o}, 32'd1);
      check("hold_iaddr", instr_addr_o, 32'h40);
      if (i < 3) step();
    end
    gnt_lat = 0;
    step();
    check("hold_after_gnt", {31'd0, instr_req_o}, 32'd0);
    wait_idle("hold");

    // Redirect while 0x104 is in flight: its data must never surface.
    expect_word(32'h100);
    expect_word(32'h200);
    rv_lat = 2;
    req_i = 1; branch_i = 1; addr_i = 32'h100;
    step();
    branch_i = 0;
    wait_req(32'h104, "rdisc_req104");
    step();
    check("rdisc_in_rvalid", {31'd0, instr_req_o}, 32'd0);
    branch_i = 1; addr_i = 32'h200;
    step();
    branch_i = 0;
    wait_req(32'h200, "rdisc_req200");
    req_i = 0;
    rv_lat = 0;
    wait_idle("rdisc");

    // Branch coincident with pop and rvalid: FIFO empties, nothing stale.
    rv_lat = 1;
    ready_i = 0; req_i = 1; branch_i = 1; addr_i = 32'h300;
    step();
    branch_i = 0;
    wait_req(32'h304, "coin_req304");
    check("coin_head", addr_o, 32'h300);
    step();
    step();
    check("coin_rvalid_now", {31'd0, instr_rvalid_i}, 32'd1);
    check("coin_valid_pre", {31'd0, valid_o}, 32'd1);
    ready_i = 1; branch_i = 1; addr_i = 32'h400; req_i = 0;
    step();
    branch_i = 0;
    check("coin_empty", {31'd0, valid_o}, 32'd0);
    check("coin_busy", {31'd0, busy_o}, 32'd0);
    step();
    step();
    check("coin_no_stale", {31'd0, valid_o}, 32'd0);
    rv_lat = 0;
    expect_word(32'h400);
    req_i = 1;
    wait_req(32'h400, "coin_req400");
    req_i = 0;
    wait_idle("coin");

    // Asynchronous reset while waiting for a grant, then a late response.
    ready_i = 0; req_i = 1; branch_i = 1; addr_i = 32'h500;
    step();
    branch_i = 0;
    wait_req(32'h500, "arst_req500");
    gnt_lat = 5;
    wait_req(32'h504, "arst_req504");
    check("arst_pre_valid", {31'd0, valid_o}, 32'd1);
    check("arst_pre_head", addr_o, 32'h500);
    #1 rst_n = 1'b0;
    #1;
    check("arst_req", {31'd0, instr_req_o}, 32'd0);
    check("arst_valid", {31'd0, valid_o}, 32'd0);
    check("arst_busy", {31'd0, busy_o}, 32'd0);
    check("arst_rdata", rdata_o, 32'd0);
    check("arst_addr", addr_o, 32'd0);
    check("arst_iaddr", instr_addr_o, 32'd0);
    req_i = 0; instr_gnt_i = 0;
    pend = 0; gcount = 0; gnt_lat = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    instr_rvalid_i = 1; instr_rdata_i = 32'hDEAD_BEEF;
    step();
    step();
    check("late_rvalid_valid", {31'd0, valid_o}, 32'd0);
    check("late_rvalid_busy", {31'd0, busy_o}, 32'd0);
    check("late_rvalid_req", {31'd0, instr_req_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
